// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state codes, score width,
// parameter defaults and saturating score arithmetic.
package pong_pkg;

    localparam int SCORE_W             = 5;
    localparam int STATE_W             = 3;
    localparam int MAX_SCORE_DEF_P     = 5;
    localparam int MAX_SCORE_MIN_P     = 1;
    localparam int MAX_SCORE_LIM_P     = 21;
    localparam int END_HOLD_FRAMES_P   = 60;

    typedef enum logic [STATE_W-1:0] {
        ST_MENU      = 3'd0,
        ST_SET       = 3'd1,
        ST_START     = 3'd2,
        ST_PLAY      = 3'd3,
        ST_END_POINT = 3'd4,
        ST_END_GAME  = 3'd5
    } state_e;

    typedef logic [SCORE_W-1:0] score_t;

    function automatic score_t sat_inc(input score_t v, input score_t lim);
        return (v >= lim) ? lim : v + score_t'(1);
    endfunction

    function automatic score_t sat_dec(input score_t v, input score_t lim);
        return (v <= lim) ? lim : v - score_t'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Frame-sampled rising-edge detector: a button event is a 1 sample following
// a 0 sample, asserted only during the frame_tick cycle that takes the sample.
module btn_edge
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick_i,
    input  logic btn_i,
    output logic rise_o
);

    logic sample_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b0;
        end else if (frame_tick_i) begin
            sample_q <= btn_i;
        end
    end

    assign rise_o = frame_tick_i & btn_i & ~sample_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: menu, max-score setup, serve, rally, point hold and
// game-over, with scoring driven by wall hits from the ball datapath.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_SCORE_DEF   = MAX_SCORE_DEF_P,
    parameter int MAX_SCORE_MIN   = MAX_SCORE_MIN_P,
    parameter int MAX_SCORE_LIM   = MAX_SCORE_LIM_P,
    parameter int END_HOLD_FRAMES = END_HOLD_FRAMES_P
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               btn_launch,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               left_hit,
    input  logic               right_hit,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [SCORE_W-1:0] max_score,
    output logic               start_player,
    output logic               winner,
    output logic               ball_enable,
    output logic               serve_load
);

    localparam int     HOLD_W    = $clog2(END_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD_FRAMES - 1);
    localparam score_t MAX_DEF   = score_t'(MAX_SCORE_DEF);
    localparam score_t MAX_MIN   = score_t'(MAX_SCORE_MIN);
    localparam score_t MAX_LIM   = score_t'(MAX_SCORE_LIM);

    logic launch_ev, up_ev, down_ev;

    btn_edge u_launch (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick_i (frame_tick),
        .btn_i        (btn_launch),
        .rise_o       (launch_ev)
    );

    btn_edge u_up (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick_i (frame_tick),
        .btn_i        (btn_up),
        .rise_o       (up_ev)
    );

    btn_edge u_down (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick_i (frame_tick),
        .btn_i        (btn_down),
        .rise_o       (down_ev)
    );

    state_e              state_q, state_d;
    score_t              s1_q, s1_d, s2_q, s2_d, max_q, max_d;
    logic                sp_q, sp_d, win_q, win_d;
    logic                ball_en_q, ball_en_d, serve_q, serve_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        max_d   = max_q;
        sp_d    = sp_q;
        win_d   = win_q;
        hold_d  = hold_q;

        case (state_q)
            ST_MENU: begin
                if (launch_ev) state_d = ST_SET;
            end
            ST_SET: begin
                if (up_ev && !down_ev) begin
                    max_d = sat_inc(max_q, MAX_LIM);
                end else if (down_ev && !up_ev) begin
                    max_d = sat_dec(max_q, MAX_MIN);
                end
                if (launch_ev) begin
                    state_d = ST_START;
                    s1_d    = '0;
                    s2_d    = '0;
                    sp_d    = 1'b0;
                end
            end
            ST_START: begin
                if (launch_ev) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Simultaneous hits void the point but still end the rally.
                if (left_hit || right_hit) begin
                    state_d = ST_END_POINT;
                    hold_d  = '0;
                    if (right_hit && !left_hit) begin
                        s1_d = sat_inc(s1_q, max_q);
                        sp_d = 1'b1;
                    end else if (left_hit && !right_hit) begin
                        s2_d = sat_inc(s2_q, max_q);
                        sp_d = 1'b0;
                    end
                end
            end
            ST_END_POINT: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if (s1_q == max_q || s2_q == max_q) begin
                            state_d = ST_END_GAME;
                            win_d   = (s2_q == max_q);
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_END_GAME: begin
                if (launch_ev) begin
                    state_d = ST_MENU;
                    s1_d    = '0;
                    s2_d    = '0;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase

        ball_en_d = (state_d == ST_PLAY);
        serve_d   = (state_d == ST_START) && (state_q != ST_START);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_MENU;
            s1_q      <= '0;
            s2_q      <= '0;
            max_q     <= MAX_DEF;
            sp_q      <= 1'b0;
            win_q     <= 1'b0;
            hold_q    <= '0;
            ball_en_q <= 1'b0;
            serve_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            max_q     <= max_d;
            sp_q      <= sp_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            ball_en_q <= ball_en_d;
            serve_q   <= serve_d;
        end
    end

    assign state        = state_q;
    assign score_p1     = s1_q;
    assign score_p2     = s2_q;
    assign max_score    = max_q;
    assign start_player = sp_q;
    assign winner       = win_q;
    assign ball_enable  = ball_en_q;
    assign serve_load   = serve_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios plus a
// randomized run, all compared cycle by cycle against a rule-level model.
module tb_pong_game_ctrl;

    localparam int S_MENU = 0, S_SET = 1, S_START = 2, S_PLAY = 3, S_ENDPT = 4, S_ENDGM = 5;
    localparam int HOLD = 60, DEF_MAX = 5, MIN_MAX = 1, LIM_MAX = 21;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0, btn_launch = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       left_hit = 1'b0, right_hit = 1'b0;
    logic [2:0] state;
    logic [4:0] score_p1, score_p2, max_score;
    logic       start_player, winner, ball_enable, serve_load;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .btn_launch   (btn_launch),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .left_hit     (left_hit),
        .right_hit    (right_hit),
        .state        (state),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .max_score    (max_score),
        .start_player (start_player),
        .winner       (winner),
        .ball_enable  (ball_enable),
        .serve_load   (serve_load)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Rule-level reference model
    int m_st, m_s1, m_s2, m_max, m_sp, m_win, m_hold, m_sl;
    bit m_pl, m_pu, m_pd;

    task automatic model_reset();
        m_st = S_MENU; m_s1 = 0; m_s2 = 0; m_max = DEF_MAX;
        m_sp = 0; m_win = 0; m_hold = 0; m_sl = 0;
        m_pl = 0; m_pu = 0; m_pd = 0;
    endtask

    task automatic model_update(bit tk, bit l, bit u, bit d, bit lh, bit rh);
        bit el, eu, ed;
        int nxt;
        el = tk && l && !m_pl;
        eu = tk && u && !m_pu;
        ed = tk && d && !m_pd;
        if (tk) begin m_pl = l; m_pu = u; m_pd = d; end
        nxt = m_st;
        if (m_st == S_MENU) begin
            if (el) nxt = S_SET;
        end else if (m_st == S_SET) begin
            if (eu && !ed && m_max < LIM_MAX) m_max = m_max + 1;
            if (ed && !eu && m_max > MIN_MAX) m_max = m_max - 1;
            if (el) begin nxt = S_START; m_s1 = 0; m_s2 = 0; m_sp = 0; end
        end else if (m_st == S_START) begin
            if (el) nxt = S_PLAY;
        end else if (m_st == S_PLAY) begin
            if (lh || rh) begin
                nxt = S_ENDPT;
                m_hold = 0;
                if (rh && !lh) begin
                    if (m_s1 < m_max) m_s1++;
                    m_sp = 1;
                end else if (lh && !rh) begin
                    if (m_s2 < m_max) m_s2++;
                    m_sp = 0;
                end
            end
        end else if (m_st == S_ENDPT) begin
            if (tk) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    if (m_s1 == m_max || m_s2 == m_max) begin
                        nxt = S_ENDGM;
                        m_win = (m_s2 == m_max) ? 1 : 0;
                    end else begin
                        nxt = S_START;
                    end
                end
            end
        end else if (m_st == S_ENDGM) begin
            if (el) begin nxt = S_MENU; m_s1 = 0; m_s2 = 0; end
        end
        m_sl = (nxt == S_START && m_st != S_START) ? 1 : 0;
        m_st = nxt;
    endtask

    function automatic logic [21:0] exp_vec();
        return {3'(m_st), 5'(m_s1), 5'(m_s2), 5'(m_max), 1'(m_sp), 1'(m_win),
                1'(m_st == S_PLAY), 1'(m_sl)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {state, score_p1, score_p2, max_score, start_player, winner, ball_enable, serve_load};
    endfunction

    // Called at a negedge: drive inputs, let one posedge pass, compare at next negedge.
    task automatic step(bit tk, bit l, bit u, bit d, bit lh, bit rh);
        frame_tick = tk; btn_launch = l; btn_up = u; btn_down = d;
        left_hit = lh; right_hit = rh;
        model_update(tk, l, u, d, lh, rh);
        @(negedge clk);
        chk("cyc", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic press(bit l, bit u, bit d);
        step(1, l, u, d, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_scores"}, 32'({score_p1, score_p2}), 0);
        chk({tag, "_max"}, 32'(max_score), DEF_MAX);
        chk({tag, "_flags"}, 32'({start_player, winner, ball_enable, serve_load}), 0);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic mid_reset(string tag);
        frame_tick = 0; left_hit = 0; right_hit = 0;
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    bit tk, bl, bu, bd, lh, rh;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;

        // Launch held over three frames yields a single event
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("menu_to_set", 32'(state), S_SET);

        // max_score saturation both ways, and up+down cancelling
        for (int i = 0; i < 20; i++) press(0, 1, 0);
        chk("max_up20", 32'(max_score), 21);
        for (int i = 0; i < 2; i++) press(0, 1, 0);
        chk("max_sat_hi", 32'(max_score), 21);
        for (int i = 0; i < 25; i++) press(0, 0, 1);
        chk("max_sat_lo", 32'(max_score), 1);
        press(0, 1, 1);
        chk("max_updown", 32'(max_score), 1);
        press(0, 1, 0);
        press(0, 1, 0);

        step(1, 1, 0, 0, 0, 0);
        chk("start_serve", 32'({state, serve_load}), {3'(S_START), 1'b1});
        step(1, 0, 0, 0, 0, 0);
        chk("serve_once", 32'(serve_load), 0);
        press(1, 0, 0);
        chk("play_ball_en", 32'({state, ball_enable}), {3'(S_PLAY), 1'b1});

        // P1 point, hold, back to START
        step(0, 0, 0, 0, 0, 1);
        chk("p1_point", 32'({state, score_p1, start_player}), {3'(S_ENDPT), 5'd1, 1'b1});
        ticks(HOLD - 1);
        chk("hold_59", 32'(state), S_ENDPT);
        ticks(1);
        chk("hold_done", 32'({state, serve_load}), {3'(S_START), 1'b1});
        step(0, 0, 0, 0, 0, 0);
        chk("serve_pulse_end", 32'(serve_load), 0);

        // Void point
        press(1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("void_point", 32'({state, score_p1, score_p2, start_player}),
            {3'(S_ENDPT), 5'd1, 5'd0, 1'b1});
        ticks(HOLD);
        chk("void_resume", 32'(state), S_START);

        // Short game won by P2
        mid_reset("rst_start");
        press(1, 0, 0);
        for (int i = 0; i < 3; i++) press(0, 0, 1);
        chk("max_2", 32'(max_score), 2);
        press(1, 0, 0);
        for (int g = 0; g < 2; g++) begin
            press(1, 0, 0);
            step(0, 0, 0, 0, 1, 0);
            ticks(HOLD);
        end
        chk("game_over", 32'({state, winner, score_p2}), {3'(S_ENDGM), 1'b1, 5'd2});
        press(1, 0, 0);
        chk("back_menu", 32'({state, score_p1, score_p2, max_score}),
            {3'(S_MENU), 5'd0, 5'd0, 5'd2});

        // Reset during PLAY acts without a clock edge
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("pre_rst_play", 32'(state), S_PLAY);
        mid_reset("rst_play");
        step(0, 0, 0, 0, 0, 0);

        // Randomized play
        bl = 0; bu = 0; bd = 0;
        for (int i = 0; i < 6000; i++) begin
            tk = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) bl = ~bl;
            if ($urandom_range(0, 5) == 0) bu = ~bu;
            if ($urandom_range(0, 5) == 0) bd = ~bd;
            lh = ($urandom_range(0, 11) == 0);
            rh = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1499) == 0) mid_reset("rst_rand");
            step(tk, bl, bu, bd, lh, rh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
